// File: rtl/io_sw_driver_pkg.sv
// Shared definitions for the switch-input stimulus driver: word layout and FSM state codes.
package io_sw_driver_pkg;

  localparam int unsigned IO_W      = 32;
  localparam int unsigned PAYLOAD_W = 31;
  localparam int unsigned VALID_BIT = 31;
  localparam int unsigned ST_W      = 2;

  localparam logic [ST_W-1:0] ST_IDLE     = 2'd0;
  localparam logic [ST_W-1:0] ST_PRESENT  = 2'd1;
  localparam logic [ST_W-1:0] ST_GAP_WAIT = 2'd2;

  function automatic logic [IO_W-1:0] mk_valid_word(input logic [PAYLOAD_W-1:0] payload);
    return {1'b1, payload};
  endfunction

endpackage

// File: rtl/sw_stim_fifo.sv
// Stimulus FIFO: power-of-two depth, wrapping pointers, exact occupancy count.
module sw_stim_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 31,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head_c,
  output logic [CW-1:0] count,
  output logic          full_c
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic          do_push;
  logic          do_pop;

  // Push is refused when full so stored words are never overwritten.
  always_comb begin
    do_push  = push && (count_q != CW'(DEPTH));
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_c = mem_q[rd_ptr_q];
  assign count  = count_q;
  assign full_c = (count_q == CW'(DEPTH));

endmodule

// File: rtl/io_sw_driver.sv
// Feeds queued stimulus words onto a DUT switch input, one per program acknowledgement.
module io_sw_driver
  import io_sw_driver_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter logic [31:0] ACK_PC  = 32'h0000_0010,
  parameter int unsigned GAP     = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_load_vld,
  input  logic [30:0]            i_load_data,
  output logic                   o_load_rdy,
  input  logic [31:0]            i_pc_debug,
  input  logic                   i_insn_vld,
  output logic [31:0]            o_io_sw,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_busy,
  output logic                   o_timeout
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned GW = $clog2(GAP + 2);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP == 0) ? 0 : GAP - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [ST_W-1:0]      state_q, state_d;
  logic [IO_W-1:0]      io_sw_q, io_sw_d;
  logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
  logic [TW-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic                 timeout_q, timeout_d;
  logic                 pop_c;
  logic                 ack_c;
  logic                 have_word_c;
  logic                 fifo_full_c;
  logic [PAYLOAD_W-1:0] fifo_head_c;
  logic [CW-1:0]        fifo_count;

  sw_stim_fifo #(
    .DEPTH (DEPTH),
    .W     (PAYLOAD_W)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_reset),
    .push      (i_load_vld),
    .push_data (i_load_data),
    .pop       (pop_c),
    .head_c    (fifo_head_c),
    .count     (fifo_count),
    .full_c    (fifo_full_c)
  );

  assign ack_c       = i_insn_vld && (i_pc_debug == ACK_PC);
  assign have_word_c = (fifo_count != '0);

  // Next state; a gap that ends with words queued presents directly so the
  // VALID-low spacing between back-to-back words is exactly GAP cycles.
  always_comb begin
    state_d   = state_q;
    io_sw_d   = io_sw_q;
    gap_cnt_d = gap_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    timeout_d = timeout_q;
    pop_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        io_sw_d = '0;
        if (have_word_c) begin
          pop_c     = 1'b1;
          io_sw_d   = mk_valid_word(fifo_head_c);
          tmo_cnt_d = '0;
          state_d   = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (ack_c) begin
          io_sw_d   = '0;
          gap_cnt_d = '0;
          state_d   = (GAP == 0) ? ST_IDLE : ST_GAP_WAIT;
        end else begin
          if (tmo_cnt_q != TW'(TIMEOUT)) begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
          end
          if (tmo_cnt_q == TMO_LAST) begin
            timeout_d = 1'b1;
          end
        end
      end
      ST_GAP_WAIT: begin
        io_sw_d = '0;
        if (gap_cnt_q == GAP_LAST) begin
          if (have_word_c) begin
            pop_c     = 1'b1;
            io_sw_d   = mk_valid_word(fifo_head_c);
            tmo_cnt_d = '0;
            state_d   = ST_PRESENT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: begin
        io_sw_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q   <= ST_IDLE;
      io_sw_q   <= '0;
      gap_cnt_q <= '0;
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      io_sw_q   <= io_sw_d;
      gap_cnt_q <= gap_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Ready stays high through reset; the FIFO drops anything offered then.
  assign o_load_rdy = !i_reset || !fifo_full_c;
  assign o_io_sw    = io_sw_q;
  assign o_count    = fifo_count;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_io_sw_driver.sv
// Directed bench for io_sw_driver: sequencing, flow control, hold, timeout and reset.
module tb_io_sw_driver;
  import io_sw_driver_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_vld;
  logic [30:0] load_data;
  logic        load_rdy;
  logic [31:0] pc;
  logic        insn_vld;
  logic [31:0] io_sw;
  logic [4:0]  count;
  logic        busy;
  logic        timeout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  io_sw_driver #(
    .DEPTH   (16),
    .ACK_PC  (32'h0000_0010),
    .GAP     (2),
    .TIMEOUT (1024)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_load_vld  (load_vld),
    .i_load_data (load_data),
    .o_load_rdy  (load_rdy),
    .i_pc_debug  (pc),
    .i_insn_vld  (insn_vld),
    .o_io_sw     (io_sw),
    .o_count     (count),
    .o_busy      (busy),
    .o_timeout   (timeout)
  );

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ack_once();
    insn_vld = 1'b1;
    pc       = 32'h0000_0010;
    step();
    insn_vld = 1'b0;
    pc       = 32'h0;
  endtask

  initial begin
    rst_n     = 1'b0;
    load_vld  = 1'b1;
    load_data = 31'h7;
    pc        = 32'h0;
    insn_vld  = 1'b0;

    // Reset state; load offered during reset is dropped.
    step(2);
    chk("rst_io_sw", io_sw, 32'h0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_load_rdy", 32'(load_rdy), 32'd1);
    load_vld = 1'b0;
    rst_n    = 1'b1;
    step();
    chk("rst_load_discarded", 32'(count), 32'd0);

    // Three words, each acked; two VALID-low cycles between words.
    load_vld  = 1'b1;
    load_data = 31'h41;
    step();
    chk("lat_count", 32'(count), 32'd1);
    chk("lat_io_low", io_sw, 32'h0);
    load_data = 31'h42;
    step();
    chk("w41_present", io_sw, 32'h8000_0041);
    chk("push_pop_count", 32'(count), 32'd1);
    load_data = 31'h43;
    step();
    load_vld = 1'b0;
    chk("count_two", 32'(count), 32'd2);
    chk("w41_held", io_sw, 32'h8000_0041);
    ack_once();
    chk("gap1_a", io_sw, 32'h0);
    chk("gap_busy", 32'(busy), 32'd1);
    step();
    chk("gap2_a", io_sw, 32'h0);
    step();
    chk("w42_present", io_sw, 32'h8000_0042);
    chk("w42_count", 32'(count), 32'd1);
    ack_once();
    chk("gap1_b", io_sw, 32'h0);
    step();
    chk("gap2_b", io_sw, 32'h0);
    step();
    chk("w43_present", io_sw, 32'h8000_0043);
    chk("w43_count", 32'(count), 32'd0);
    ack_once();
    step(2);
    chk("seq_idle_io", io_sw, 32'h0);
    chk("seq_idle_busy", 32'(busy), 32'd0);
    chk("seq_idle_count", 32'(count), 32'd0);

    // Non-acks must not advance.
    load_vld  = 1'b1;
    load_data = 31'h55;
    step();
    load_vld = 1'b0;
    step();
    chk("w55_present", io_sw, 32'h8000_0055);
    pc       = 32'h0000_0010;
    insn_vld = 1'b0;
    step();
    chk("noack_insn_low", io_sw, 32'h8000_0055);
    insn_vld = 1'b1;
    pc       = 32'h0000_0014;
    step();
    chk("noack_pc14", io_sw, 32'h8000_0055);
    pc = 32'h8000_0010;
    step();
    chk("noack_pc_hi_bits", io_sw, 32'h8000_0055);
    chk("noack_valid_bit", 32'(io_sw[VALID_BIT]), 32'd1);
    insn_vld = 1'b0;
    pc       = 32'h0;
    ack_once();
    step(2);
    chk("w55_done_busy", 32'(busy), 32'd0);

    // Timeout: flag rises 1024 cycles after VALID rose, word keeps presenting.
    load_vld  = 1'b1;
    load_data = 31'h66;
    step();
    load_vld = 1'b0;
    step();
    chk("w66_present", io_sw, 32'h8000_0066);
    step(1023);
    chk("tmo_not_yet", 32'(timeout), 32'd0);
    step();
    chk("tmo_set", 32'(timeout), 32'd1);
    chk("tmo_still_valid", io_sw, 32'h8000_0066);

    // Fill while a word is held: 16 accepted, 17th refused.
    for (int i = 0; i < 17; i++) begin
      load_vld  = 1'b1;
      load_data = 31'(32'h100 + i);
      chk($sformatf("fill_rdy_%0d", i), 32'(load_rdy), (i < 16) ? 32'd1 : 32'd0);
      step();
    end
    load_vld = 1'b0;
    chk("full_count", 32'(count), 32'd16);
    chk("full_rdy", 32'(load_rdy), 32'd0);
    chk("full_w66_held", io_sw, 32'h8000_0066);

    // Drain in order across the pointer wrap; the refused word never shows.
    for (int i = 0; i < 16; i++) begin
      ack_once();
      chk($sformatf("drain_gap_%0d", i), io_sw, 32'h0);
      step(2);
      chk($sformatf("drain_word_%0d", i), io_sw, 32'h8000_0100 + 32'(i));
      chk($sformatf("drain_count_%0d", i), 32'(count), 32'(15 - i));
    end
    ack_once();
    step(2);
    chk("drain_idle_io", io_sw, 32'h0);
    chk("drain_idle_busy", 32'(busy), 32'd0);
    chk("tmo_sticky", 32'(timeout), 32'd1);

    // Reset mid-PRESENT with five words queued.
    for (int i = 0; i < 6; i++) begin
      load_vld  = 1'b1;
      load_data = 31'(32'h200 + i);
      step();
    end
    load_vld = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd5);
    chk("pre_rst_io", io_sw, 32'h8000_0200);
    rst_n = 1'b0;
    step();
    chk("mid_rst_io", io_sw, 32'h0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;
    step(3);
    chk("post_rst_io", io_sw, 32'h0);
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/io_sw_driver.md
IO_SW_DRIVER -- requirements
Module: io_sw_driver

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DEPTH, 16, stimulus FIFO entries (power of two, >=2)
- ACK_PC, 32'h0000_0010, PC value at which the DUT consumes the presented word
- GAP, 2, idle cycles with VALID low between consecutive words
- TIMEOUT, 1024, cycles allowed in PRESENT before a timeout is flagged
REQ-002 Ports (name, direction, width, meaning), clock and reset first:
- i_clk, in, 1, single clock; all logic on rising edge
- i_reset, in, 1, synchronous reset, active-low
- i_load_vld, in, 1, testbench offers a stimulus word
- i_load_data, in, 31, stimulus payload
- o_load_rdy, out, 1, FIFO can accept a word
- i_pc_debug, in, 32, DUT program counter
- i_insn_vld, in, 1, DUT instruction-valid qualifier
- o_io_sw, out, 32, drives DUT switch input; [31]=VALID, [30:0]=payload
- o_count, out, $clog2(DEPTH)+1, current FIFO occupancy
- o_busy, out, 1, FSM not in IDLE
- o_timeout, out, 1, sticky timeout flag

Function
REQ-003 Load transfer occurs on a cycle with i_load_vld && o_load_rdy; o_load_rdy = (o_count < DEPTH), combinational.
REQ-004 Load while full is ignored; the FIFO shall not be overwritten and o_count shall not change.
REQ-005 FIFO read/write pointers shall wrap modulo DEPTH; o_count shall track occupancy exactly, including simultaneous load and pop (count unchanged).
REQ-006 FSM states: IDLE, PRESENT, GAP_WAIT.
REQ-007 IDLE: o_io_sw = 32'h0; when o_count > 0, pop head into output register and go to PRESENT next cycle.
REQ-008 PRESENT: o_io_sw = {1'b1, held payload}; payload stable for the whole state.
REQ-009 Ack = i_insn_vld && (i_pc_debug == ACK_PC); ack in PRESENT moves to GAP_WAIT next cycle; ack outside PRESENT is ignored.
REQ-010 GAP_WAIT: o_io_sw = 32'h0 for exactly GAP cycles, then IDLE; with GAP = 0, return to IDLE immediately.
REQ-011 A word loaded in the same cycle the FIFO becomes empty is presented; empty-then-load latency to VALID high shall be 2 cycles.
REQ-012 Timeout counter counts cycles in PRESENT, clears on entry; at TIMEOUT cycles without ack, set o_timeout (sticky) and continue presenting (no drop).
REQ-013 o_busy = (state != IDLE).
REQ-014 Payload width arithmetic: ACK_PC compare full 32 bits; no truncation of i_load_data.

Reset
REQ-015 When i_reset is low at a rising edge: state = IDLE, pointers = 0, o_count = 0, o_io_sw = 32'h0, o_timeout = 0, timeout counter = 0, GAP counter = 0.
REQ-016 Reset mid-PRESENT shall discard the held word and all FIFO contents; VALID low on the first cycle after reset.
REQ-017 o_load_rdy shall be high during reset, but loads offered while i_reset is low are discarded.

Structure
REQ-018 The FSM state enum and the VALID bit index belong in the shared testbench package.
REQ-019 The FIFO is a sub-module named sw_stim_fifo (DEPTH, 31-bit payload, push/pop/count); FSM, timeout and gap counters live in io_sw_driver.
REQ-020 Block is bench-side, synthesizable style, no delays or $-tasks in the datapath.

Verification
REQ-021 Load 3 words 0x41,0x42,0x43; ack each at PC=0x10 -> o_io_sw sequence 0x8000_0041, 0x0 x2, 0x8000_0042, 0x0 x2, 0x8000_0043, then IDLE, o_count=0.
REQ-022 Load 17 words with DEPTH=16 -> 17th refused (o_load_rdy low), o_count=16; 17th never appears on o_io_sw.
REQ-023 Ack with i_insn_vld=0 or PC=0x14 -> no advance, payload held, VALID stays 1.
REQ-024 Present word, no ack for 1024 cycles -> o_timeout=1 at cycle 1024, VALID still 1; later ack advances normally, o_timeout stays 1.
REQ-025 Drive i_reset low during PRESENT with 5 words queued -> next cycle o_io_sw=0, o_count=0, o_busy=0, o_timeout=0.
REQ-026 Simultaneous load and pop at o_count=1 -> o_count stays 1, loaded word presented after current word.
